// File: rtl/ldpc_pkg.sv
// Shared definitions for LDPC check-node and variable-node blocks.
//   - FSM state encodings used by the frame-level decoders
//   - default LLR width
//   - symmetric LLR clamp, clamped magnitude and saturating add helpers.
//     They work on 32-bit signed containers with the real width passed
//     as an argument, so every block can reuse them whatever its LLR_W
//     is (LLR_W must stay below 32).
package ldpc_pkg;

  localparam int LLR_W_DEF = 8;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_UPDATE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Largest representable LLR of width w in the symmetric range.
  function automatic logic signed [31:0] llr_max(input int w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  // Map the single asymmetric code -2^(w-1) onto -(2^(w-1)-1).
  function automatic logic signed [31:0] clamp_sym(input logic signed [31:0] a,
                                                   input int w);
    logic signed [31:0] lim;
    lim = llr_max(w);
    return (a < -lim) ? -lim : a;
  endfunction

  // |a| limited to 2^(w-1)-1, so it always fits in w-1 bits.
  function automatic logic [31:0] abs_clamp(input logic signed [31:0] a,
                                            input int w);
    logic signed [31:0] m;
    m = (a < 0) ? -a : a;
    if (m > llr_max(w)) m = llr_max(w);
    return m;
  endfunction

  // a + b with one guard bit, saturated to +/-(2^(w-1)-1).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] s;
    logic signed [32:0] lim;
    s   = {a[31], a} + {b[31], b};
    lim = (33'sd1 <<< (w - 1)) - 33'sd1;
    if (s > lim)       s = lim;
    else if (s < -lim) s = -lim;
    return s[31:0];
  endfunction

endpackage

// File: rtl/spc_min2_tracker.sv
// Streaming two-minimum tracker for a min-sum check node.
// For every enabled sample it folds the sample's sign into a running
// parity and keeps the two smallest magnitudes plus the index of the
// smallest. Ties keep the earlier index, so min2 may equal min1.
// Ports:
//   clk, rst   clock, synchronous active-low reset
//   clear      restart tracking (takes priority over en)
//   en         sample valid this cycle
//   llr        signed sample, idx its position in the frame
//   min1/min2  smallest / second smallest magnitude (init all-ones)
//   idx1       position of min1
//   sgn_par    XOR of all sample signs so far
module spc_min2_tracker
  import ldpc_pkg::*;
#(
  parameter int LLR_W = LLR_W_DEF,
  parameter int IDX_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [LLR_W-1:0] llr,
  input  logic [IDX_W-1:0]        idx,
  output logic [LLR_W-2:0]        min1,
  output logic [LLR_W-2:0]        min2,
  output logic [IDX_W-1:0]        idx1,
  output logic                    sgn_par
);

  logic [LLR_W-2:0] mag;

  always_comb begin
    mag = (LLR_W-1)'(abs_clamp(32'(llr), LLR_W));
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      min1    <= '1;
      min2    <= '1;
      idx1    <= '0;
      sgn_par <= 1'b0;
    end else if (en) begin
      sgn_par <= sgn_par ^ llr[LLR_W-1];
      if (mag < min1) begin
        min2 <= min1;
        min1 <= mag;
        idx1 <= idx;
      end else if (mag < min2) begin
        min2 <= mag;
      end
    end
  end

endmodule

// File: rtl/spc_minsum_decoder.sv
// Min-sum decoder for one single-parity-check LDPC check node.
// A frame of N_VAR channel LLRs is loaded serially, then each variable
// gets its extrinsic message (min magnitude of the others, parity of the
// other signs) added to its channel LLR, one variable per cycle. The
// finished frame is published with a one-cycle done pulse.
// Ports:
//   clk, rst    clock, synchronous active-low reset
//   in_valid    in_llr valid; in_ready high only while loading
//   in_llr      channel LLR, frame order 0..N_VAR-1, positive => bit 0
//   done        one-cycle pulse when bits/post_llr/parity_ok update
//   bits        hard decisions, bit i = variable i
//   post_llr    posterior LLR i at [i*LLR_W +: LLR_W], saturated
//   parity_ok   1 when the hard decisions satisfy the check
// Build option: define OFFSET_MINSUM_EN for offset min-sum (extrinsic
// magnitude reduced by OFFSET, floored at 0); otherwise plain min-sum.
module spc_minsum_decoder
  import ldpc_pkg::*;
#(
  parameter int N_VAR  = 8,
  parameter int LLR_W  = LLR_W_DEF,
  parameter int OFFSET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [LLR_W-1:0]  in_llr,
  output logic                     done,
  output logic [N_VAR-1:0]         bits,
  output logic [N_VAR*LLR_W-1:0]   post_llr,
  output logic                     parity_ok
);

  localparam int               IDX_W = $clog2(N_VAR);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_VAR - 1);
  localparam logic [LLR_W-2:0] OFF_V = (LLR_W-1)'(OFFSET);

  logic [1:0]              state;
  logic [IDX_W-1:0]        count;
  logic                    accept;
  logic signed [LLR_W-1:0] llr_buf [N_VAR];
  logic [N_VAR*LLR_W-1:0]  post_acc;
  logic [N_VAR-1:0]        bits_acc;

  logic [LLR_W-2:0]        min1;
  logic [LLR_W-2:0]        min2;
  logic [IDX_W-1:0]        idx1;
  logic                    sgn_par;

  logic signed [LLR_W-1:0] cur;
  logic [LLR_W-2:0]        emag_raw;
  logic [LLR_W-2:0]        emag;
  logic                    esgn;
  logic signed [LLR_W:0]   ext_mag;
  logic signed [LLR_W:0]   ext;
  logic signed [LLR_W-1:0] sum;
  logic                    offset_unused;

  assign in_ready      = (state == ST_LOAD);
  assign accept        = in_valid && in_ready;
  assign offset_unused = ^OFF_V;

  spc_min2_tracker #(
    .LLR_W (LLR_W),
    .IDX_W (IDX_W)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ST_DONE),
    .en      (accept),
    .llr     (in_llr),
    .idx     (count),
    .min1    (min1),
    .min2    (min2),
    .idx1    (idx1),
    .sgn_par (sgn_par)
  );

  // Update datapath: count doubles as the variable index during UPDATE.
  always_comb begin
    cur      = llr_buf[count];
    emag_raw = (count == idx1) ? min2 : min1;
`ifdef OFFSET_MINSUM_EN
    emag     = (emag_raw > OFF_V) ? (emag_raw - OFF_V) : '0;
`else
    emag     = emag_raw;
`endif
    esgn     = sgn_par ^ cur[LLR_W-1];
    ext_mag  = {2'b00, emag};
    ext      = esgn ? -ext_mag : ext_mag;
    sum      = LLR_W'(sat_add(32'(cur), 32'(ext), LLR_W));
  end

  // Control and published outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_LOAD;
      count     <= '0;
      done      <= 1'b0;
      bits      <= '0;
      post_llr  <= '0;
      parity_ok <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (count == LAST) begin
              count <= '0;
              state <= ST_UPDATE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ST_UPDATE: begin
          if (count == LAST) begin
            count <= '0;
            state <= ST_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_DONE: begin
          done      <= 1'b1;
          bits      <= bits_acc;
          post_llr  <= post_acc;
          parity_ok <= ~^bits_acc;
          state     <= ST_LOAD;
        end
        default: begin
          state <= ST_LOAD;
          count <= '0;
        end
      endcase
    end
  end

  // Frame buffer and per-variable results; held until overwritten.
  always_ff @(posedge clk) begin
    if (accept) begin
      llr_buf[count] <= LLR_W'(clamp_sym(32'(in_llr), LLR_W));
    end
    if (state == ST_UPDATE) begin
      post_acc[count*LLR_W +: LLR_W] <= sum;
      bits_acc[count]                <= sum[LLR_W-1];
    end
  end

endmodule

// File: tb/tb_spc_minsum_decoder.sv
// Self-checking bench for spc_minsum_decoder (N_VAR=4, LLR_W=8).
// Expected results come from a hand-computed vector table (with an
// alternative table when OFFSET_MINSUM_EN is defined) and are matched
// against each done pulse through a scoreboard queue.
module tb_spc_minsum_decoder;

  localparam int NV = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_llr = '0;
  logic        done;
  logic [3:0]  bits;
  logic [31:0] post_llr;
  logic        parity_ok;

  typedef struct packed {
    logic [31:0] post;
    logic [3:0]  bits;
    logic        par;
  } exp_t;

  typedef struct packed {
    logic [31:0] llr;
    exp_t        exp;
    logic        gaps;
  } vec_t;

  vec_t  vecs [NV];
  exp_t  sb [$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    acc_cnt  = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;

  spc_minsum_decoder #(
    .N_VAR  (4),
    .LLR_W  (8),
    .OFFSET (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_llr    (in_llr),
    .done      (done),
    .bits      (bits),
    .post_llr  (post_llr),
    .parity_ok (parity_ok)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    logic [31:0] r;
    r = {d[7:0], c[7:0], b[7:0], a[7:0]};
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] llr, input logic [31:0] post,
                              input logic [3:0] b, input logic p, input logic g);
    vec_t v;
    v.llr = llr; v.exp.post = post; v.exp.bits = b; v.exp.par = p; v.gaps = g;
    return v;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending frame.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      done_cyc = cyc;
      check("done_without_frame", 32'(sb.size() == 0), 32'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("post_llr", post_llr, e.post);
        check("bits", 32'(bits), 32'(e.bits));
        check("parity_ok", 32'(parity_ok), 32'(e.par));
      end
    end
  end

  // Drive one frame; with gaps the valid line toggles 1,0,1,0...
  // in_valid stays asserted with the last sample afterwards.
  task automatic send_frame(input logic [31:0] llr, input logic gaps, output int last_cyc);
    int i = 0;
    int tries = 0;
    logic tog = 1'b1;
    logic acc;
    last_cyc = 0;
    while (i < 4 && tries < 400) begin
      in_llr   = llr[i*8 +: 8];
      in_valid = gaps ? tog : 1'b1;
      tog      = ~tog;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        i++;
        last_cyc = cyc;
      end
      tries++;
    end
    if (i < 4) check("send_timeout", i, 4);
  endtask

  // Wait until all pending frames are reported, then drop in_valid
  // before the decoder could take the held sample as a new frame.
  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk); #1;
      w++;
    end
    in_valid = 1'b0;
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int last;
    int base_acc;
    int base_done;

`ifdef OFFSET_MINSUM_EN
    vecs[0] = mk(pack4(20, 5, 9, 30),     pack4(24, 13, 13, 34),     4'b0000, 1'b1, 1'b1);
    vecs[1] = mk(pack4(20, -5, 9, 30),    pack4(16, 3, 5, 26),       4'b0000, 1'b1, 1'b0);
    vecs[2] = mk(pack4(100, 100, 100, 100), pack4(127, 127, 127, 127), 4'b0000, 1'b1, 1'b1);
    vecs[3] = mk(pack4(-128, 3, 3, 3),    pack4(-125, 1, 1, 1),      4'b0001, 1'b0, 1'b0);
    vecs[4] = mk(pack4(-10, -20, -30, -40), pack4(-29, -29, -39, -49), 4'b1111, 1'b1, 1'b0);
    vecs[5] = mk(pack4(0, 7, 7, -1),      pack4(0, 7, 7, -1),        4'b1000, 1'b0, 1'b1);
    vecs[6] = mk(pack4(4, 4, 9, -9),      pack4(1, 1, 6, -6),        4'b1000, 1'b0, 1'b0);
    vecs[7] = mk(pack4(-100, -100, -100, -100), pack4(-127, -127, -127, -127), 4'b1111, 1'b1, 1'b0);
`else
    vecs[0] = mk(pack4(20, 5, 9, 30),     pack4(25, 14, 14, 35),     4'b0000, 1'b1, 1'b1);
    vecs[1] = mk(pack4(20, -5, 9, 30),    pack4(15, 4, 4, 25),       4'b0000, 1'b1, 1'b0);
    vecs[2] = mk(pack4(100, 100, 100, 100), pack4(127, 127, 127, 127), 4'b0000, 1'b1, 1'b1);
    vecs[3] = mk(pack4(-128, 3, 3, 3),    pack4(-124, 0, 0, 0),      4'b0001, 1'b0, 1'b0);
    vecs[4] = mk(pack4(-10, -20, -30, -40), pack4(-30, -30, -40, -50), 4'b1111, 1'b1, 1'b0);
    vecs[5] = mk(pack4(0, 7, 7, -1),      pack4(-1, 7, 7, -1),       4'b1001, 1'b1, 1'b1);
    vecs[6] = mk(pack4(4, 4, 9, -9),      pack4(0, 0, 5, -5),        4'b1000, 1'b0, 1'b0);
    vecs[7] = mk(pack4(-100, -100, -100, -100), pack4(-127, -127, -127, -127), 4'b1111, 1'b1, 1'b0);
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bits", 32'(bits), 32'd0);
    check("rst_post", post_llr, 32'd0);
    check("rst_parity", 32'(parity_ok), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Latency, in_ready drop and held-valid behaviour on a single frame
    base_acc = acc_cnt;
    sb.push_back(vecs[0].exp);
    send_frame(vecs[0].llr, 1'b0, last);
    check("in_ready_in_update", 32'(in_ready), 32'd0);
    drain();
    check("done_latency", done_cyc - last, 5);
    check("accepts_single", acc_cnt - base_acc, 4);

    // Table vectors sent back to back
    base_acc = acc_cnt;
    for (int k = 0; k < NV; k++) begin
      sb.push_back(vecs[k].exp);
      send_frame(vecs[k].llr, vecs[k].gaps, last);
    end
    drain();
    check("accepts_table", acc_cnt - base_acc, 4 * NV);

    // Reset in the middle of a frame
    in_valid = 1'b1;
    in_llr   = 8'd50;
    @(posedge clk); #1;
    in_llr   = 8'd60;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst      = 1'b1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_bits", 32'(bits), 32'd0);
    check("mid_rst_post", post_llr, 32'd0);
    check("mid_rst_parity", 32'(parity_ok), 32'd0);
    base_done = done_cnt;
    sb.push_back(vecs[0].exp);
    send_frame(vecs[0].llr, 1'b0, last);
    drain();
    repeat (12) @(posedge clk);
    #1;
    check("done_count_after_rst", done_cnt - base_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
